filtro_antirrebote: RTL and testbench

- Debounces the raw push-button. Produces the clean level `botonLimpio` that the pulse-to-impulse stage turns into a single-cycle `impulso` for the memory controller.
- Sits directly upstream of that stage.
- Contains a two-flop synchronizer, a stability counter and a 4-state confirm FSM.
- Output is a level, not a pulse. Edge detection stays downstream.

---
 rtl/filtro_antirrebote.sv | 118 +++++++++++
 tb/tb_filtro_antirrebote.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/filtro_antirrebote.sv
// Push-button debouncer: two-flop synchronizer, stability counter and a
// four-state confirm FSM producing a registered clean level.
module filtro_antirrebote #(
  parameter int CICLOS_ESTABLE = 500000,
  parameter int ANCHO_CONTADOR = 20,
  parameter int ACTIVO_ALTO    = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botonSucio,
  output logic       botonLimpio,
  output logic       estable,
  output logic [1:0] estado_o
);

  typedef enum logic [1:0] {
    REPOSO           = 2'd0,
    CONFIRMA_PRESION = 2'd1,
    PRESIONADO       = 2'd2,
    CONFIRMA_LIBERA  = 2'd3
  } estado_t;

  localparam logic [ANCHO_CONTADOR-1:0] OBJETIVO = ANCHO_CONTADOR'(CICLOS_ESTABLE);
  localparam logic [ANCHO_CONTADOR-1:0] UNO      = ANCHO_CONTADOR'(1);
  localparam logic [ANCHO_CONTADOR-1:0] CERO     = '0;
  localparam logic                      INVIERTE = (ACTIVO_ALTO == 0);

  logic                      sync1_q, sync2_q;
  estado_t                   estado_q, estado_d;
  logic [ANCHO_CONTADOR-1:0] cnt_q, cnt_d;
  logic                      limpio_q, limpio_d;
  logic                      estable_q, estable_d;

  // Polarity is normalised at the first flop so the FSM always sees 1 = pressed.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= botonSucio ^ INVIERTE;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= REPOSO;
      cnt_q     <= CERO;
      limpio_q  <= 1'b0;
      estable_q <= 1'b1;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      limpio_q  <= limpio_d;
      estable_q <= estable_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    limpio_d = limpio_q;
    case (estado_q)
      REPOSO: begin
        if (sync2_q) begin
          estado_d = CONFIRMA_PRESION;
          cnt_d    = UNO;
        end else begin
          cnt_d = CERO;
        end
      end
      CONFIRMA_PRESION: begin
        // Any sample back at the old level throws away the whole count.
        if (!sync2_q) begin
          estado_d = REPOSO;
          cnt_d    = CERO;
        end else if (cnt_q == OBJETIVO) begin
          estado_d = PRESIONADO;
          limpio_d = 1'b1;
          cnt_d    = CERO;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      PRESIONADO: begin
        if (!sync2_q) begin
          estado_d = CONFIRMA_LIBERA;
          cnt_d    = UNO;
        end else begin
          cnt_d = CERO;
        end
      end
      CONFIRMA_LIBERA: begin
        if (sync2_q) begin
          estado_d = PRESIONADO;
          cnt_d    = CERO;
        end else if (cnt_q == OBJETIVO) begin
          estado_d = REPOSO;
          limpio_d = 1'b0;
          cnt_d    = CERO;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      default: begin
        estado_d = REPOSO;
        limpio_d = 1'b0;
        cnt_d    = CERO;
      end
    endcase
    estable_d = (estado_d == REPOSO) || (estado_d == PRESIONADO);
  end

  assign botonLimpio = limpio_q;
  assign estable     = estable_q;
  assign estado_o    = estado_q;

endmodule

// File: tb/tb_filtro_antirrebote.sv
// Bench for filtro_antirrebote: active-high and active-low instances share
// stimulus; a run-length reference feeds an expected queue checked each cycle.
module tb_filtro_antirrebote;

  localparam int C = 4;

  logic       clock;
  logic       reset;
  logic       botonSucio;
  logic       botonSucio_n;
  logic       limpio_a, estable_a, limpio_b, estable_b;
  logic [1:0] estado_a, estado_b;

  logic [1:0] exp_q[$];
  int         n_vec;
  int         n_err;

  // Reference: synchronizer delay plus a count of consecutive edges where
  // the synchronized level disagrees with the clean output.
  logic m1, m2, mlim;
  int   run;

  // Downstream edge detector standing in for the pulse stage.
  logic lim_prev, impulso, impulso_prev;
  int   n_impulsos;

  assign botonSucio_n = ~botonSucio;

  filtro_antirrebote #(.CICLOS_ESTABLE(C), .ANCHO_CONTADOR(20), .ACTIVO_ALTO(1)) dut_a (
    .clock(clock), .reset(reset), .botonSucio(botonSucio),
    .botonLimpio(limpio_a), .estable(estable_a), .estado_o(estado_a)
  );

  filtro_antirrebote #(.CICLOS_ESTABLE(C), .ANCHO_CONTADOR(20), .ACTIVO_ALTO(0)) dut_b (
    .clock(clock), .reset(reset), .botonSucio(botonSucio_n),
    .botonLimpio(limpio_b), .estable(estable_b), .estado_o(estado_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) lim_prev <= 1'b0;
    else       lim_prev <= limpio_a;
  end
  assign impulso = limpio_a & ~lim_prev;

  task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nombre, act, req, $time);
    end
  endtask

  // Monitor: pops one expected {botonLimpio, estable} per clocked edge.
  always @(negedge clock) begin
    logic [1:0] e;
    if (!reset && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("inst_a_limpio_estable", {30'd0, limpio_a, estable_a}, {30'd0, e});
      chk("inst_b_limpio_estable", {30'd0, limpio_b, estable_b}, {30'd0, e});
    end
    if (!reset) begin
      if (impulso) n_impulsos++;
      if (impulso && impulso_prev) chk("impulso_width", 32'd2, 32'd1);
      impulso_prev = impulso;
    end else begin
      impulso_prev = 1'b0;
    end
  end

  task automatic model_reset();
    m1 = 1'b0; m2 = 1'b0; mlim = 1'b0; run = 0;
  endtask

  task automatic model_edge(input logic raw);
    logic s;
    s  = m2;
    m2 = m1;
    m1 = raw;
    if (s != mlim) begin
      run++;
      if (run == C + 1) begin
        mlim = ~mlim;
        run  = 0;
      end
    end else begin
      run = 0;
    end
    exp_q.push_back({mlim, (run == 0)});
  endtask

  // Drive one raw value for one clock edge; returns 1 time unit after it.
  task automatic ciclo(input logic v);
    botonSucio = v;
    @(posedge clock);
    model_edge(v);
    #1;
  endtask

  task automatic ciclos(input logic v, input int n);
    for (int i = 0; i < n; i++) ciclo(v);
  endtask

  task automatic pulso_reset(input int n_ciclos);
    @(negedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_limpio", {31'd0, limpio_a}, 32'd0);
    chk("async_reset_estable", {31'd0, estable_a}, 32'd1);
    chk("async_reset_estado", {30'd0, estado_a}, 32'd0);
    model_reset();
    repeat (n_ciclos) @(posedge clock);
    @(negedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_impulsos = 0; impulso_prev = 1'b0;
    botonSucio = 1'b0;
    model_reset();
    reset = 1'b1;
    #3;
    chk("reset_limpio", {31'd0, limpio_a}, 32'd0);
    chk("reset_estable", {31'd0, estable_a}, 32'd1);
    #97;
    chk("reset_end_limpio", {31'd0, limpio_a}, 32'd0);
    chk("reset_end_estable", {31'd0, estable_a}, 32'd1);
    @(negedge clock);
    #1;
    reset = 1'b0;

    // Idle after release: nothing may move.
    for (int i = 0; i < 20; i++) begin
      ciclo(1'b0);
      chk("idle_limpio", {31'd0, limpio_a}, 32'd0);
      chk("idle_estado", {30'd0, estado_a}, 32'd0);
    end

    // Clean press: edge k is the first ciclo(1).
    ciclos(1'b1, 2);
    chk("press_estable_k1", {31'd0, estable_a}, 32'd1);
    ciclo(1'b1);
    chk("press_estable_k2", {31'd0, estable_a}, 32'd0);
    chk("press_estado_k2", {30'd0, estado_a}, 32'd1);
    ciclos(1'b1, 3);
    chk("press_limpio_k5", {31'd0, limpio_a}, 32'd0);
    ciclo(1'b1);
    chk("press_limpio_k6", {31'd0, limpio_a}, 32'd1);
    chk("press_estable_k6", {31'd0, estable_a}, 32'd1);
    chk("press_estado_k6", {30'd0, estado_a}, 32'd2);
    ciclos(1'b1, 4);

    // Release with a 3-cycle glitch back to 1 mid-confirmation.
    ciclos(1'b0, 3);
    ciclos(1'b1, 3);
    chk("glitch_limpio_held", {31'd0, limpio_a}, 32'd1);
    ciclos(1'b0, 6);
    chk("release_limpio_k5", {31'd0, limpio_a}, 32'd1);
    ciclo(1'b0);
    chk("release_limpio_k6", {31'd0, limpio_a}, 32'd0);
    ciclos(1'b0, 4);

    // Bouncy press: 1,1,0,0 x3 then held.
    for (int r = 0; r < 3; r++) begin
      ciclos(1'b1, 2);
      ciclos(1'b0, 2);
      chk("bounce_limpio", {31'd0, limpio_a}, 32'd0);
    end
    ciclos(1'b1, 6);
    chk("bounce_limpio_k5", {31'd0, limpio_a}, 32'd0);
    ciclo(1'b1);
    chk("bounce_limpio_k6", {31'd0, limpio_a}, 32'd1);
    ciclos(1'b1, 3);

    ciclos(1'b0, 10);
    chk("release2_limpio", {31'd0, limpio_a}, 32'd0);

    // Reset while confirming a press with cnt = 3, button kept held.
    ciclos(1'b1, 5);
    chk("midconfirm_estado", {30'd0, estado_a}, 32'd1);
    pulso_reset(2);
    ciclos(1'b1, 6);
    chk("post_reset_limpio_k5", {31'd0, limpio_a}, 32'd0);
    ciclo(1'b1);
    chk("post_reset_limpio_k6", {31'd0, limpio_a}, 32'd1);
    ciclos(1'b1, 3);

    // Reset while pressed drops the clean level at once; held button re-confirms.
    pulso_reset(1);
    ciclos(1'b1, 7);
    chk("reconfirm_limpio", {31'd0, limpio_a}, 32'd1);
    ciclos(1'b0, 10);

    // Pulse of 4 cycles (one short of C+1) never reaches the output.
    ciclos(1'b1, 4);
    ciclos(1'b0, 10);
    chk("short_pulse_limpio", {31'd0, limpio_a}, 32'd0);

    @(negedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("impulso_count", n_impulsos, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
